// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM states and the index-width helper.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

  // A 2-entry index still needs one bit, hence the floor of 1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin search: first set request strictly after last_owner, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]              req,
  input  logic [idx_w(NREQ)-1:0]       last_owner,
  output logic                         pick_vld,
  output logic [idx_w(NREQ)-1:0]       pick_id
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_owner) + k) % NREQ);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-locked round-robin arbiter feeding a single FIFO write port.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic                      grant_vld,
  output logic [idx_w(NREQ)-1:0]    grant_id
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = idx_w(MAXBURST + 1);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] gid_q, gid_nxt;
  logic [IW-1:0] last_owner, lo_nxt;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic          pick_vld;
  logic [IW-1:0] pick_id;
  logic          beat, rel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last_owner (last_owner),
    .pick_vld   (pick_vld),
    .pick_id    (pick_id)
  );

  // Reset gates the beat so a packet abandoned by reset issues nothing more.
  assign beat = (state == LOCK) & req_valid[gid_q] & ~wfull & ~wrst;
  assign rel  = beat & (req_last[gid_q] | (beat_cnt == CW'(MAXBURST - 1)));

  always_comb begin
    state_nxt = state;
    gid_nxt   = gid_q;
    lo_nxt    = last_owner;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = LOCK;
          gid_nxt   = pick_id;
          cnt_nxt   = '0;
        end
      end
      LOCK: begin
        if (rel) begin
          state_nxt = IDLE;
          lo_nxt    = gid_q;
          cnt_nxt   = '0;
        end else if (beat) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_owner resets to the top index so requester 0 is searched first.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state      <= IDLE;
      gid_q      <= '0;
      last_owner <= IW'(NREQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gid_q      <= gid_nxt;
      last_owner <= lo_nxt;
      beat_cnt   <= cnt_nxt;
    end
  end

  assign winc      = beat;
  assign wdata     = req_data[int'(gid_q)*DSIZE +: DSIZE];
  assign req_ready = beat ? (NREQ'(1) << gid_q) : '0;
  assign grant_vld = (state == LOCK) & ~wrst;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: direct-drive vector table plus scoreboarded packet sequences.
module tb_fifo_wr_arb;
  localparam int DSIZE = 8, NREQ = 4, MAXBURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid, req_last, req_ready;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull, winc, grant_vld;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            grant_id;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant_vld(grant_vld), .grant_id(grant_id)
  );

  always #5 wclk = ~wclk;

  typedef struct packed { logic l; logic [7:0] d; } beat_t;
  typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;
  typedef struct { logic [3:0] v; logic f; logic winc; logic [3:0] rdy; logic gv; } row_t;

  int        n_cmp = 0, n_bad = 0;
  beat_t     src [NREQ][$];
  exp_t      sb[$];
  logic [NREQ-1:0] en;
  bit        sb_on, use_src;
  logic      gv_tr[$], winc_tr[$];
  logic [1:0] gid_tr[$];
  row_t      rows[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (src[i].size() > 0) begin
        req_valid[i] = en[i];
        req_data[i*DSIZE +: DSIZE] = src[i][0].d;
        req_last[i] = src[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DSIZE +: DSIZE] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  // One cycle: sample/score at negedge, then advance requester sources after posedge.
  task automatic tick();
    logic [NREQ-1:0] rdy;
    @(negedge wclk);
    rdy = req_ready;
    gv_tr.push_back(grant_vld);
    gid_tr.push_back(grant_id);
    winc_tr.push_back(winc);
    if (sb_on) begin
      if (winc) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_extra: got write id %0d data %0h, expected none", grant_id, wdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", grant_id, e.id);
          chk("sb_data", wdata, e.d);
          chk("sb_ready", req_ready, 4'b0001 << e.id);
        end
      end else
        chk("idle_ready", req_ready, 0);
    end
    @(posedge wclk); #1;
    for (int i = 0; i < NREQ; i++)
      if (rdy[i] && src[i].size() > 0) void'(src[i].pop_front());
    if (use_src) drive();
  endtask

  task automatic check_pat(input string nm, input int sel, input string pat);
    for (int k = 0; k < pat.len(); k++) begin
      if (k >= gv_tr.size()) begin
        n_cmp++; n_bad++;
        $display("FAIL %s[%0d]: got no sample expected %s", nm, k, pat.substr(k, k));
      end else
        chk($sformatf("%s[%0d]", nm, k), sel ? winc_tr[k] : gv_tr[k], pat[k] == "1");
    end
  endtask

  task automatic clear_tr();
    gv_tr.delete(); gid_tr.delete(); winc_tr.delete();
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    for (int i = 0; i < NREQ; i++) src[i].delete();
    sb.delete();
    en = '1; wfull = 1'b0; use_src = 1; sb_on = 1;
    drive();
    tick(); tick();
    chk("rst_gv", gv_tr[$], 0);
    chk("rst_winc", winc_tr[$], 0);
    wrst = 1'b0;
    clear_tr();
  endtask

  task automatic push_src(input int i, input int k, input logic l, input bit score);
    beat_t b;
    b.d = 8'(i*16 + k); b.l = l;
    src[i].push_back(b);
    if (score) sb.push_back({2'(i), b.d});
  endtask

  initial begin
    wrst = 1'b1; en = '1; wfull = 1'b0; use_src = 1; sb_on = 1;
    drive();

    // Vector table: owner 2 locked, probe beat gating under various inputs.
    rows[0] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1};
    rows[1] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1};
    rows[2] = '{4'b1011, 1'b0, 1'b0, 4'b0000, 1'b1};
    rows[3] = '{4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1};
    rows[4] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1};
    rows[5] = '{4'b1111, 1'b0, 1'b1, 4'b0100, 1'b1};
    rows[6] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1};
    rows[7] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1};
    do_reset();
    use_src = 0; sb_on = 0;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    req_last = '0; req_valid = 4'b0100; wfull = 1'b1;
    tick();
    chk("tbl_arb_gv0", gv_tr[0], 0);
    for (int r = 0; r < 8; r++) begin
      req_valid = rows[r].v; wfull = rows[r].f;
      @(negedge wclk);
      chk($sformatf("row%0d_winc", r), winc, rows[r].winc);
      chk($sformatf("row%0d_ready", r), req_ready, rows[r].rdy);
      chk($sformatf("row%0d_gv", r), grant_vld, rows[r].gv);
      chk($sformatf("row%0d_gid", r), grant_id, 2);
      chk($sformatf("row%0d_wdata", r), wdata, 8'h30);
      @(posedge wclk); #1;
    end

    // Two requesters, 2-beat packets: order 1,2,1,2 with a bubble between grants.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int k = 2*p; k < 2*p+2; k++) push_src(1, k, k[0], 1);
      for (int k = 2*p; k < 2*p+2; k++) push_src(2, k, k[0], 1);
    end
    drive();
    repeat (14) tick();
    check_pat("a_gv", 0, "01101101101100");
    chk("a_gid1", gid_tr[1], 1); chk("a_gid4", gid_tr[4], 2);
    chk("a_gid7", gid_tr[7], 1); chk("a_gid10", gid_tr[10], 2);
    chk("a_sb_empty", sb.size(), 0);

    // No req_last: burst limit forces release after MAXBURST beats.
    do_reset();
    for (int k = 0; k < 6; k++) push_src(0, k, 1'b0, 1);
    drive();
    repeat (9) tick();
    check_pat("b_gv", 0, "011110111");
    check_pat("b_winc", 1, "011110110");
    chk("b_sb_empty", sb.size(), 0);

    // Full stall mid-packet: burst count must hold across the stall.
    do_reset();
    for (int k = 0; k < 5; k++) push_src(2, k, 1'b0, 1);
    drive();
    tick(); tick();
    wfull = 1'b1;
    repeat (5) tick();
    wfull = 1'b0;
    repeat (6) tick();
    check_pat("c_gv", 0, "0111111111011");
    check_pat("c_winc", 1, "0100000111010");
    for (int k = 2; k <= 6; k++) chk($sformatf("c_gid%0d", k), gid_tr[k], 2);
    chk("c_sb_empty", sb.size(), 0);

    // All four valid with single-beat packets: strict rotation.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push_src(i, k, 1'b1, 1);
    drive();
    repeat (17) tick();
    check_pat("d_gv", 0, "01010101010101010");
    chk("d_sb_empty", sb.size(), 0);

    // Owner 3 goes quiet mid-packet while 0 waits: lock persists.
    do_reset();
    push_src(3, 0, 1'b0, 1); push_src(3, 1, 1'b0, 1); push_src(3, 2, 1'b1, 1);
    push_src(0, 0, 1'b1, 1);
    en = 4'b1000; drive();
    tick(); tick();
    en = 4'b0001; drive();
    repeat (3) tick();
    en = 4'b1111; drive();
    repeat (5) tick();
    check_pat("e_gv", 0, "0111111010");
    check_pat("e_winc", 1, "0100011010");
    for (int k = 2; k <= 4; k++) chk($sformatf("e_gid%0d", k), gid_tr[k], 3);
    chk("e_gid8", gid_tr[8], 0);
    chk("e_sb_empty", sb.size(), 0);

    // Reset after two beats abandons the lock; lowest valid index wins afterwards.
    do_reset();
    push_src(1, 0, 1'b0, 1); push_src(1, 1, 1'b0, 1);
    for (int k = 2; k < 5; k++) push_src(1, k, 1'b0, 0);
    push_src(3, 0, 1'b1, 0);
    drive();
    repeat (3) tick();
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    sb.push_back({2'd1, 8'(16 + 2)});
    repeat (2) tick();
    check_pat("f_gv", 0, "011001");
    check_pat("f_winc", 1, "011001");
    chk("f_gid5", gid_tr[5], 1);
    chk("f_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DSIZE, default 8: data width of each requester and of the FIFO write port.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter MAXBURST, default 4: maximum beats per grant before forced rotation; legal range 1..16.
REQ-004 wclk  input  1  write-domain clock; the only clock; all state updates on rising edge.
REQ-005 wrst  input  1  reset, synchronous to wclk and active-high.
REQ-006 req_valid  input  NREQ  per-requester beat-available flag.
REQ-007 req_data  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 req_last  input  NREQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-009 req_ready  output  NREQ  per-requester beat-accepted flag.
REQ-010 wfull  input  1  FIFO full flag, write domain.
REQ-011 winc  output  1  FIFO write enable.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 grant_vld  output  1  high while a requester owns the write port.
REQ-014 grant_id  output  clog2(NREQ)  index of the current owner; meaningful only when grant_vld=1.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and LOCK.
REQ-016 In IDLE with any req_valid set, the FSM SHALL select the first set requester searching from (last_owner+1) mod NREQ upward with wrap, load grant_id, clear beat_cnt, and enter LOCK on the next edge.
REQ-017 In IDLE with no req_valid set, the FSM SHALL remain in IDLE.
REQ-018 Arbitration latency SHALL be exactly one cycle: grant_vld rises on the edge following the first cycle with a set req_valid in IDLE.
REQ-019 grant_vld SHALL be 1 exactly when the state is LOCK.
REQ-020 A beat SHALL be defined as LOCK & req_valid[grant_id] & !wfull.
REQ-021 winc SHALL equal the beat condition combinationally, and wdata SHALL equal req_data of grant_id.
REQ-022 req_ready[i] SHALL equal the beat condition for i==grant_id and SHALL be 0 for every other i.
REQ-023 beat_cnt SHALL increment on each beat and SHALL never exceed MAXBURST.
REQ-024 The owner SHALL be released on a beat with req_last[grant_id]=1 or with beat_cnt==MAXBURST-1; the FSM then enters IDLE and last_owner takes grant_id.
REQ-025 After a release, the FSM SHALL spend exactly one IDLE bubble cycle before the next LOCK.
REQ-026 While wfull=1 in LOCK, no beat SHALL occur and state, grant_id and beat_cnt SHALL hold.
REQ-027 If the owner deasserts req_valid mid-packet, the lock SHALL persist and no other requester SHALL be granted.
REQ-028 A requester that is not the owner SHALL never see req_ready=1, whatever its req_valid.
REQ-029 With MAXBURST=1, every beat SHALL release the owner.

Reset
REQ-030 On a wclk edge with wrst=1, the state SHALL become IDLE, beat_cnt 0, grant_id 0, and last_owner NREQ-1, so requester 0 has first priority.
REQ-031 During and immediately after reset, winc, req_ready and grant_vld SHALL be 0.
REQ-032 Reset mid-packet SHALL abandon the lock with no further beat issued; the FIFO contents are the FIFO's concern.

Structure
REQ-033 Package fifo_arb_pkg SHALL hold the state enumeration (IDLE, LOCK) and the index-width function used for grant_id and last_owner.
REQ-034 The round-robin search SHALL be a separate combinational sub-module rr_pick with inputs req and last_owner and outputs pick_vld and pick_id.

Verification
REQ-035 After reset, req_valid=0b0110 held, packets of 2 beats -> grant order 1,2,1,2, each grant preceded by one bubble cycle.
REQ-036 req_valid=0b0001, req_last never set, MAXBURST=4 -> exactly 4 winc pulses, then release, bubble, and regrant to 0 on the next edge.
REQ-037 Owner 2 is mid-packet when wfull is asserted for 5 cycles -> winc=0 for those 5 cycles, grant_id stays 2, beat_cnt is unchanged, and the stream resumes without loss.
REQ-038 All four requesters are valid with single-beat packets -> grant_id sequence is 0,1,2,3,0, and each requester's wdata appears in that order.
REQ-039 Owner 3 drops req_valid for 3 cycles while req 0 is valid -> no grant to 0 until 3 sends req_last.
REQ-040 wrst is asserted in LOCK after 2 beats -> on the next cycle grant_vld=0 and winc=0, and the first post-reset grant goes to the lowest valid index.
